// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the pad input path:
//   - state_e     : poll FSM state encoding
//   - PAD_*       : bit positions in the order the pad shifts them out
//   - IN_*        : bit positions of the decoded input_data word
//   - map_buttons : pad order -> input_data order, with opposing-direction
//                   cancellation (up+down, left+right)
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Pad serial order (bit index of the shift register)
  localparam int PAD_B      = 0;
  localparam int PAD_Y      = 1;
  localparam int PAD_SELECT = 2;
  localparam int PAD_START  = 3;
  localparam int PAD_UP     = 4;
  localparam int PAD_DOWN   = 5;
  localparam int PAD_LEFT   = 6;
  localparam int PAD_RIGHT  = 7;
  localparam int PAD_A      = 8;
  localparam int PAD_X      = 9;
  localparam int PAD_L      = 10;
  localparam int PAD_R      = 11;
  localparam int PAD_BITS   = 12;

  // Decoded input_data positions
  localparam int IN_SELECT  = 0;
  localparam int IN_START   = 1;
  localparam int IN_Y       = 2;
  localparam int IN_X       = 3;
  localparam int IN_SWORD   = 4;
  localparam int IN_UP      = 5;
  localparam int IN_DOWN    = 6;
  localparam int IN_LEFT    = 7;
  localparam int IN_RIGHT   = 8;
  localparam int IN_ATTACK  = 9;

  // Only pad bits 0..9 matter; L and R are not mapped to any game input.
  function automatic logic [9:0] map_buttons(input logic [9:0] pressed);
    logic [9:0] r;
    r             = 10'b0;
    r[IN_ATTACK]  = pressed[PAD_A];
    r[IN_RIGHT]   = pressed[PAD_RIGHT] & ~pressed[PAD_LEFT];
    r[IN_LEFT]    = pressed[PAD_LEFT]  & ~pressed[PAD_RIGHT];
    r[IN_DOWN]    = pressed[PAD_DOWN]  & ~pressed[PAD_UP];
    r[IN_UP]      = pressed[PAD_UP]    & ~pressed[PAD_DOWN];
    r[IN_SWORD]   = pressed[PAD_B];
    r[IN_X]       = pressed[PAD_X];
    r[IN_Y]       = pressed[PAD_Y];
    r[IN_START]   = pressed[PAD_START];
    r[IN_SELECT]  = pressed[PAD_SELECT];
    return r;
  endfunction

endpackage

// File: rtl/pad_phase_timer.sv
// -----------------------------------------------------------------------------
// pad_phase_timer
// Counts HALF_PERIOD clk cycles while run_i is high and pulses phase_done_o
// in the last cycle of each half-period. The count restarts immediately, so
// back-to-back phases are seamless. Held at zero whenever run_i is low.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   run_i        in   count enable (high during LATCH / SHIFT_LO / SHIFT_HI)
//   phase_done_o out  high in the final cycle of a half-period
// -----------------------------------------------------------------------------
module pad_phase_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic phase_done_o
);

  localparam logic [5:0] LAST_CNT = 6'(HALF_PERIOD - 1);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  assign phase_done_o = run_i && (cnt_q == LAST_CNT);

  // Next-count: clear when idle or at end of a half-period, otherwise count up
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = 6'd0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = 6'd0;
    end else begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Phase counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/input_controller.sv
// -----------------------------------------------------------------------------
// input_controller
// Polls an SNES-style serial pad once per frame_tick and publishes the decoded
// buttons on input_data with a one-cycle trigger pulse.
//
// Poll timing (HP = HALF_PERIOD): LATCH for 2*HP cycles, then 12 bits each of
// HP cycles pad_clk low + HP cycles pad_clk high, then one DONE cycle. The
// trigger lands 1+26*HP cycles after the accepting frame_tick cycle.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   frame_tick  in   poll request; ignored unless idle
//   pad_data    in   pad serial data, active-low
//   pad_latch   out  parallel-load strobe to the pad
//   pad_clk     out  shift clock to the pad, idles high
//   input_data  out  decoded buttons (see game_pkg IN_*)
//   trigger     out  one-cycle pulse when input_data updates
//   busy        out  high while a poll is in progress
//
// Build option: define ATTACK_EDGE_EN to make input_data[9] report only a new
// press of A (pressed now, not pressed on the previous completed poll).
// -----------------------------------------------------------------------------
module input_controller
  import game_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [9:0] input_data,
  output logic       trigger,
  output logic       busy
);

  localparam logic [3:0] LAST_IDX = 4'(PAD_BITS - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [11:0] shift_q;
  logic [11:0] shift_d;
  logic        pad_latch_q;
  logic        pad_clk_q;
  logic [9:0]  input_data_q;
  logic        trigger_q;
  logic        busy_q;
  logic [9:0]  next_data_s;
  logic        run_s;
  logic        phase_done_s;
  logic        unused_lr_s;

  assign pad_latch  = pad_latch_q;
  assign pad_clk    = pad_clk_q;
  assign input_data = input_data_q;
  assign trigger    = trigger_q;
  assign busy       = busy_q;

  // L and R are shifted in to keep the bit count honest, then dropped
  assign unused_lr_s = ^shift_q[11:10];

  assign run_s = (state_q == ST_LATCH) || (state_q == ST_SHIFT_LO) ||
                 (state_q == ST_SHIFT_HI);

  pad_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run_s),
    .phase_done_o (phase_done_s)
  );

  // Shift register with the current bit (pad data inverted to active-high) merged in
  always_comb begin
    shift_d = shift_q | ({11'b0, ~pad_data} << idx_q);
  end

`ifdef ATTACK_EDGE_EN
  logic prev_a_q;

  // Decoded word; attack only on a fresh press of A
  always_comb begin
    next_data_s            = map_buttons(shift_q[9:0]);
    next_data_s[IN_ATTACK] = shift_q[PAD_A] & ~prev_a_q;
  end

  // Remember A from the last completed poll
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_a_q <= 1'b0;
    end else if ((state_q == ST_SHIFT_HI) && phase_done_s && (idx_q == LAST_IDX)) begin
      prev_a_q <= shift_q[PAD_A];
    end else begin
      prev_a_q <= prev_a_q;
    end
  end
`else
  // Decoded word; attack follows the A level of this poll
  always_comb begin
    next_data_s            = map_buttons(shift_q[9:0]);
    next_data_s[IN_ATTACK] = shift_q[PAD_A];
  end
`endif

  // Poll FSM with registered pad and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      shift_q      <= 12'd0;
      pad_latch_q  <= 1'b0;
      pad_clk_q    <= 1'b1;
      input_data_q <= 10'd0;
      trigger_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      trigger_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            state_q     <= ST_LATCH;
            idx_q       <= 4'd0;
            shift_q     <= 12'd0;
            pad_latch_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        // The latch spans two timer half-periods; idx_q counts them so the
        // 6-bit phase counter never has to reach 2*HALF_PERIOD.
        ST_LATCH: begin
          if (phase_done_s) begin
            if (idx_q == 4'd1) begin
              state_q     <= ST_SHIFT_LO;
              idx_q       <= 4'd0;
              pad_latch_q <= 1'b0;
              pad_clk_q   <= 1'b0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        // Sample in the last low cycle, just before pad_clk rises
        ST_SHIFT_LO: begin
          if (phase_done_s) begin
            shift_q   <= shift_d;
            state_q   <= ST_SHIFT_HI;
            pad_clk_q <= 1'b1;
          end
        end
        // Output registers load on entry to DONE so trigger and the new
        // input_data appear together in the DONE cycle.
        ST_SHIFT_HI: begin
          if (phase_done_s) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= ST_DONE;
              input_data_q <= next_data_s;
              trigger_q    <= 1'b1;
            end else begin
              idx_q     <= idx_q + 4'd1;
              state_q   <= ST_SHIFT_LO;
              pad_clk_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= 4'd0;
          pad_latch_q <= 1'b0;
          pad_clk_q   <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
